// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// rippling the carry between chunks through a register.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    // Operand width must split into whole chunks
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_c;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        base_c;
    logic [CHUNK-1:0]   a_chunk_c;
    logic [CHUNK-1:0]   b_chunk_c;
    logic [CHUNK-1:0]   s_chunk_c;
    logic               c_chunk_c;
    logic               accept_c;
    logic               last_c;

    assign accept_c = in_valid && in_ready;
    assign last_c   = (idx_q == IDX_W'(N - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = RUN;
            RUN:  if (last_c)   state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // One chunk of the addition, selected by the chunk index
    always_comb begin
        base_c    = 32'(idx_q) * CHUNK;
        a_chunk_c = CHUNK'(a_q >> base_c);
        b_chunk_c = CHUNK'(b_q >> base_c);
        {c_chunk_c, s_chunk_c} = (CHUNK + 1)'(a_chunk_c) + (CHUNK + 1)'(b_chunk_c)
                               + (CHUNK + 1)'(carry_q);
        res_c = (res_q & ~(CHUNK_MASK << base_c)) | (WIDTH'(s_chunk_c) << base_c);
    end

    // Operand capture, chunk accumulation and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_c;
                    carry_q <= c_chunk_c;
                    idx_q   <= last_c ? '0 : idx_q + IDX_W'(1);
                    if (last_c) begin
                        sum       <= res_c;
                        carry_out <= c_chunk_c;
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                                  && (res_c[WIDTH-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 32/8 scenarios plus exhaustive 4/4 and 4/1.
module tb_seq_chunk_adder;

    logic        clk;
    logic        rst_n;

    // 32-bit, 8-bit chunk instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        c_in, sub, carry_out, overflow;

    // 4-bit instances sharing stimulus
    logic        s_iv;
    logic [3:0]  s_a, s_b;
    logic        s_cin, s_sub;
    logic        ir1, vld1, co1, of1;
    logic [3:0]  sum1;
    logic        ir4, vld4, co4, of4;
    logic [3:0]  sum4;

    int          n_vec;
    int          n_bad;
    logic [31:0] last_sum;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(ir1),
        .a(s_a), .b(s_b), .c_in(s_cin), .sub(s_sub), .out_valid(vld1),
        .out_ready(1'b1), .sum(sum1), .carry_out(co1), .overflow(of1)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) u_n4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(ir4),
        .a(s_a), .b(s_b), .c_in(s_cin), .sub(s_sub), .out_valid(vld4),
        .out_ready(1'b1), .sum(sum4), .carry_out(co4), .overflow(of4)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one 32-bit operation, check latency/results; optionally complete the output handshake
    task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic eco, input logic eov, input logic finish);
        int cyc;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(1));
        a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0; a = $urandom; b = $urandom; c_in = ~tc; sub = ~ts;
        chk({tag, " busy"}, 64'(in_ready), 64'(0));
        chk({tag, " sum held"}, 64'(sum), 64'(last_sum));
        cyc = 0;
        do begin
            tick;
            cyc++;
        end while (!out_valid && cyc < 20);
        chk({tag, " latency"}, 64'(cyc), 64'(4));
        chk({tag, " sum"}, 64'(sum), 64'(es));
        chk({tag, " carry_out"}, 64'(carry_out), 64'(eco));
        chk({tag, " overflow"}, 64'(overflow), 64'(eov));
        last_sum = es;
        if (finish) begin
            out_ready = 1'b1;
            tick;
            out_ready = 1'b0;
            chk({tag, " out_valid drop"}, 64'(out_valid), 64'(0));
            chk({tag, " idle"}, 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        logic [3:0] beff, rs;
        logic       ci, rco, rov;
        int         lat1, lat4;

        n_vec = 0; n_bad = 0; last_sum = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        s_iv = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;

        // Reset values
        #12;
        chk("rst in_ready", 64'(in_ready), 64'(0));
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst sum", 64'(sum), 64'(0));
        chk("rst carry_out", 64'(carry_out), 64'(0));
        chk("rst overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel before edge", 64'(in_ready), 64'(0));
        tick;
        chk("rel after edge", 64'(in_ready), 64'(1));

        // Addition corner cases
        run32("add ff+1",   32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run32("add 7f+1",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        run32("add 1+1+c",  32'h1,         32'h1, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b1);

        // Subtraction, c_in ignored
        run32("sub 5-7",    32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        run32("sub 80-1",   32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);

        // Backpressure in DONE
        run32("bp op", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = $urandom; b = $urandom; sub = i[1];
            tick;
            chk($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'(0));
            chk($sformatf("bp%0d sum", i), 64'(sum), 64'h2345_6789);
        end
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; out_ready = 1'b1;
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp release out_valid", 64'(out_valid), 64'(0));
        chk("bp release in_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("bp idle%0d out_valid", i), 64'(out_valid), 64'(0));
            chk($sformatf("bp idle%0d sum", i), 64'(sum), 64'h2345_6789);
        end

        // Reset two cycles into RUN
        a = 32'hDEAD_BEEF; b = 32'h2152_4111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("abort in_ready", 64'(in_ready), 64'(0));
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort sum", 64'(sum), 64'(0));
        chk("abort carry_out", 64'(carry_out), 64'(0));
        chk("abort overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort rel before edge", 64'(in_ready), 64'(0));
        tick;
        chk("abort rel after edge", 64'(in_ready), 64'(1));
        for (int i = 0; i < 6; i++) begin
            tick;
            chk($sformatf("abort stale%0d", i), 64'(out_valid), 64'(0));
        end
        last_sum = '0;
        run32("post abort", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Exhaustive 4-bit: N=1 and N=4 instances in lockstep
        for (int k = 0; k < 1024; k++) begin
            {s_sub, s_cin, s_a, s_b} = 10'(k);
            beff = s_sub ? ~s_b : s_b;
            ci   = s_sub ? 1'b1 : s_cin;
            {rco, rs} = 5'(s_a) + 5'(beff) + 5'(ci);
            rov  = (s_a[3] == beff[3]) && (rs[3] != s_a[3]);
            s_iv = 1'b1;
            tick;
            s_iv = 1'b0; s_a = ~s_a; s_b = ~s_b;
            lat1 = 0; lat4 = 0;
            for (int c = 1; c <= 12 && (lat1 == 0 || lat4 == 0); c++) begin
                tick;
                if (vld1 && lat1 == 0) begin
                    lat1 = c;
                    chk($sformatf("n1 k%0d sum", k), 64'(sum1), 64'(rs));
                    chk($sformatf("n1 k%0d co", k), 64'(co1), 64'(rco));
                    chk($sformatf("n1 k%0d ov", k), 64'(of1), 64'(rov));
                end
                if (vld4 && lat4 == 0) begin
                    lat4 = c;
                    chk($sformatf("n4 k%0d sum", k), 64'(sum4), 64'(rs));
                    chk($sformatf("n4 k%0d co", k), 64'(co4), 64'(rco));
                    chk($sformatf("n4 k%0d ov", k), 64'(of4), 64'(rov));
                end
            end
            chk($sformatf("n1 k%0d latency", k), 64'(lat1), 64'(1));
            chk($sformatf("n4 k%0d latency", k), 64'(lat4), 64'(4));
            tick;
            chk($sformatf("k%0d both idle", k), 64'(ir1 && ir4), 64'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor; the sequential successor to the team's single-bit full adder.
- Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a carry register.
- Reports carry-out and signed overflow through valid/ready handshakes on input and output.
- Used where a full-width single-cycle carry chain would not meet timing.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK != 0 is an elaboration error. N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready, out_valid, sum, carry_out and overflow all 0.
  - Internal operand, carry and chunk counter cleared.
  - in_ready rises on the first rising edge after rst_n deasserts.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both outputs are registered.
- IDLE -> RUN on an edge where in_valid && in_ready:
  - Latch a, and b_eff = sub ? ~b : b.
  - Load carry = sub ? 1 : c_in.
  - Set chunk index = 0.
  - Input changes after acceptance have no effect.
- RUN, each edge:
  - Compute the chunk {c, s} = a[i] + b_eff[i] + carry, where i is the chunk index and chunk i covers bits [i*CHUNK +: CHUNK].
  - Store s into the result register at chunk i; carry <= c; index += 1.
  - After chunk N-1: state <= DONE, and sum, carry_out and overflow are loaded together.
- Latency: with acceptance at edge E0, out_valid rises after edge EN (N edges later). Example: WIDTH=32, CHUNK=8 gives 4 cycles.
- overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- DONE -> IDLE on an edge where out_ready=1. If out_ready is already high on entry, DONE lasts exactly one cycle.
- Throughput: one operation per N+2 cycles minimum. No overlap of consecutive operations.
- sum, carry_out and overflow:
  - Held stable throughout DONE.
  - Retain their values after DONE, through the next RUN, until the next result loads.
  - Do not change mid-computation.
- in_valid while not in IDLE is ignored, with no queuing.
- N=1 (WIDTH==CHUNK) is legal: RUN lasts one edge.
- rst_n asserted mid-RUN or in DONE aborts the operation and discards the result. No out_valid pulse follows reset release.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. The new operand is accepted no earlier than the following edge.

Test Plan:
- WIDTH=32, CHUNK=8, a=0xFFFFFFFF, b=0x1, c_in=0, sub=0 -> out_valid exactly 4 cycles after acceptance; sum=0x00000000, carry_out=1, overflow=0.
- a=0x7FFFFFFF, b=0x1, c_in=0, sub=0 -> sum=0x80000000, carry_out=0, overflow=1. Then a=0x1, b=0x1, c_in=1 -> sum=0x3, carry_out=0, overflow=0.
- Subtract, sub=1, c_in=1 (must be ignored):
  - a=5, b=7 -> sum=0xFFFFFFFE, carry_out=0, overflow=0.
  - a=0x80000000, b=0x1 -> sum=0x7FFFFFFF, carry_out=1, overflow=1.
- Backpressure: out_ready low for 10 cycles in DONE while in_valid toggles with new operands -> out_valid stays 1, sum is unchanged, in_ready stays 0, no operand is captured. Raising out_ready gives IDLE next cycle.
- Reset mid-RUN: assert rst_n low 2 cycles after acceptance -> all outputs are 0 immediately (asynchronously); after release, in_ready=1 after one edge and no stale out_valid appears.
- WIDTH=4, CHUNK=4 (N=1) and WIDTH=4, CHUNK=1 (N=4): exhaustive a, b, c_in, sub (1024 cases) -> sum, carry_out and overflow match the reference model; latency is 1 and 4 respectively.
